// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner with a double-buffered frame store.
// Optional macro SEG7_DIM_EN adds a BRIGHT[3:0] duty-cycle dimming input.
module seg7_scan_driver #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned SCAN_DIV      = 100000,
    parameter int unsigned GUARD         = 2,
    parameter bit          AN_ACTIVE_LOW = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   DATA,
    input  logic [DIGITS-1:0]     DP,
    input  logic [DIGITS-1:0]     DIGIT_EN,
    input  logic                  LOAD,
`ifdef SEG7_DIM_EN
    input  logic [3:0]            BRIGHT,
`endif
    output logic [7:0]            SEG,
    output logic [DIGITS-1:0]     AN,
    output logic                  FRAME
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{AN_ACTIVE_LOW}};

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [DIGITS-1:0]   pend_en_q, pend_en_d, act_en_q, act_en_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_q, frame_d;
`ifdef SEG7_DIM_EN
    logic [3:0]          duty_q, duty_d;
`endif

    logic                slot_end, scan_wrap, show;
    logic [3:0]          nib;
    logic                dp_sel, en_sel;
    logic [DIGITS-1:0]   an_on;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    always_comb begin
        slot_end  = (presc_q == PRESC_LAST);
        scan_wrap = slot_end && (idx_q == IDX_LAST);

        presc_d = slot_end ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end

        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_en_d   = pend_en_q;
        if (LOAD) begin
            pend_data_d = DATA;
            pend_dp_d   = DP;
            pend_en_d   = DIGIT_EN;
        end

        // A LOAD landing on the wrap cycle bypasses pending so that frame shows it.
        act_data_d = act_data_q;
        act_dp_d   = act_dp_q;
        act_en_d   = act_en_q;
        if (scan_wrap) begin
            act_data_d = LOAD ? DATA     : pend_data_q;
            act_dp_d   = LOAD ? DP       : pend_dp_q;
            act_en_d   = LOAD ? DIGIT_EN : pend_en_q;
        end

        nib    = '0;
        dp_sel = 1'b0;
        en_sel = 1'b0;
        an_on  = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib      = act_data_q[4*i +: 4];
                dp_sel   = act_dp_q[i];
                en_sel   = act_en_q[i];
                an_on[i] = 1'b1;
            end
        end

        show = (32'(presc_q) >= GUARD);
`ifdef SEG7_DIM_EN
        duty_d = duty_q + 4'd1;
        show   = show && ({1'b0, duty_q} < ({1'b0, BRIGHT} + 5'd1));
`endif

        an_d  = show ? (AN_ACTIVE_LOW ? ~an_on : an_on) : AN_OFF;
        seg_d = (show && en_sel) ? {~dp_sel, glyph(nib)} : 8'hFF;

        frame_d = scan_wrap;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q     <= '0;
            idx_q       <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pend_en_q   <= '0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_en_q    <= '0;
            seg_q       <= 8'hFF;
            an_q        <= AN_OFF;
            frame_q     <= 1'b0;
`ifdef SEG7_DIM_EN
            duty_q      <= '0;
`endif
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_en_q   <= pend_en_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_en_q    <= act_en_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            frame_q     <= frame_d;
`ifdef SEG7_DIM_EN
            duty_q      <= duty_d;
`endif
        end
    end

    assign SEG   = seg_q;
    assign AN    = an_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver against a frame-level reference model.
module tb_seg7_scan_driver;

    localparam int unsigned D  = 4;
    localparam int unsigned SD = 4;
    localparam int unsigned G  = 1;
    localparam int unsigned FR = D * SD;

    typedef struct {
        int unsigned m;
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  en;
    } load_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  en = '0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    load_t       loads[$];

    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg7_scan_driver #(
        .DIGITS(D),
        .SCAN_DIV(SD),
        .GUARD(G),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .DATA(data),
        .DP(dp),
        .DIGIT_EN(en),
        .LOAD(load),
        .SEG(seg),
        .AN(an),
        .FRAME(frame)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, want, cyc);
        end
    endtask

    // Outputs after edge n reflect scan position n; a frame shows the last load made before it began.
    task automatic expect_cycle(input int unsigned n);
        int unsigned p, idx, f;
        logic [15:0] d;
        logic [3:0]  pdp, pen, nibv;
        logic [7:0]  eseg;
        logic [3:0]  ean;
        p    = n % SD;
        idx  = (n / SD) % D;
        f    = n / FR;
        d    = '0;
        pdp  = '0;
        pen  = '0;
        eseg = 8'hFF;
        ean  = 4'hF;
        foreach (loads[k]) begin
            if (loads[k].m < f * FR) begin
                d   = loads[k].d;
                pdp = loads[k].dp;
                pen = loads[k].en;
            end
        end
        if (p >= G) begin
            ean = ~(4'b0001 << idx);
            if (pen[idx]) begin
                nibv = d[4*idx +: 4];
                eseg = {~pdp[idx], glyph_tab[nibv]};
            end
        end
        check("seg", 32'(seg), 32'(eseg));
        check("an", 32'(an), 32'(ean));
        check("frame", 32'(frame), 32'(((n + 1) % FR) == 0));
        check("one_anode", 32'($countones(~an) <= 1), 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        expect_cycle(cyc);
        cyc++;
        load = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
        data = d;
        dp   = p;
        en   = e;
        load = 1'b1;
        loads.push_back('{m: cyc, d: d, dp: p, en: e});
        step();
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic run_to_phase(input int unsigned ph);
        for (int unsigned i = 0; i < FR && (cyc % FR) != ph; i++) step();
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_seg"}, 32'(seg), 32'hFF);
        check({tag, "_an"}, 32'(an), 32'hF);
        check({tag, "_frame"}, 32'(frame), 32'd0);
    endtask

    initial begin
        repeat (3) begin
            @(posedge clk);
            #1;
            check_blank("reset");
        end
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;

        run(FR + 4);
        do_load(16'h12AF, 4'b0100, 4'hF);
        run_to_phase(0);
        run(FR);
        run_to_phase(6);
        do_load(16'h0000, 4'b0000, 4'hF);
        run_to_phase(0);
        run(FR);
        run_to_phase(FR - 1);
        do_load(16'h8888, 4'b0000, 4'hF);
        run(FR);
        do_load(16'($urandom), 4'($urandom), 4'b0101);
        run(2 * FR + 3);

        for (int unsigned i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0)
                do_load(16'($urandom), 4'($urandom), 4'($urandom));
            else
                step();
        end

        do_load(16'hFFFF, 4'hF, 4'hF);
        run_to_phase(0);
        run_to_phase(10);
        #2;
        rst = 1'b1;
        #1;
        check_blank("async_rst");
        @(posedge clk);
        #1;
        check_blank("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        loads.delete();
        run(FR + 2);
        do_load(16'($urandom), 4'($urandom), 4'hF);
        run(2 * FR);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a common-anode, DIGITS-digit seven-segment display.
- Latches a packed hex word plus per-digit decimal-point and enable flags into a double-buffered frame store.
- Scans one digit per SCAN_DIV clocks and drives shared active-low segment lines plus per-digit anode strobes.
- Sits between the timer datapath and the board display pins; supersedes per-digit combinational hex decoding.

Parameters:
- DIGITS, 4, number of digits scanned; legal range 1..8.
- SCAN_DIV, 100000, clock cycles per digit slot; must be >= GUARD+2.
- GUARD, 2, cycles at the start of each slot with all anodes off (anti-ghosting).
- AN_ACTIVE_LOW, 1, 1: anode strobe asserted low; 0: asserted high.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- DATA  in  4*DIGITS  hex nibbles; nibble i (DATA[4i+3:4i]) drives digit i; digit 0 is rightmost.
- DP  in  DIGITS  decimal point per digit, 1 = lit.
- DIGIT_EN  in  DIGITS  1 = digit shown, 0 = digit blanked.
- LOAD  in  1  single-cycle strobe; samples DATA/DP/DIGIT_EN.
- SEG  out  8  {dp,g,f,e,d,c,b,a}, all active-low; 1 = off.
- AN  out  DIGITS  anode strobes; polarity set by AN_ACTIVE_LOW.
- FRAME  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

Behaviour:
- Reset (async, immediate):
  - SEG=8'hFF; AN all inactive; FRAME=0.
  - Prescaler=0, digit index=0.
  - Pending and active stores cleared; DIGIT_EN cleared, so the display is fully blank.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - At terminal count the index advances (DIGITS-1 -> 0).
  - On that wrap, FRAME is asserted in the same cycle the index becomes 0.
- Double buffering:
  - LOAD=1 copies inputs into the pending store.
  - The pending store transfers to the active store on the cycle the index wraps to 0.
  - A frame is therefore never torn.
  - LOAD in the same cycle as the wrap bypasses the pending store and writes the active store directly.
  - Multiple LOADs within a frame: last one wins.
- Slot output (registered, 1-cycle latency from prescaler/index state):
  - Prescaler < GUARD: AN all inactive, SEG=8'hFF.
  - Otherwise AN has only bit [index] asserted.
  - If DIGIT_EN[index]=1, SEG = {~DP[index], glyph(nibble)}; if DIGIT_EN[index]=0, SEG=8'hFF.
- Glyph table (g..a, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Invariant: at most one anode asserted in any cycle.
- DIGITS=1: index is constant 0; FRAME pulses every SCAN_DIV cycles.
- Reset mid-slot: outputs go blank in the same cycle; the scan restarts at digit 0 after release.

Optional Feature:
- SEG7_DIM_EN: adds input BRIGHT [3:0].
  - Within each slot, after GUARD, the anode is asserted only while a 4-bit duty counter < BRIGHT+1.
  - The duty counter is free-running and increments every cycle.
  - BRIGHT=15 gives full on.
  - SEG is 8'hFF whenever the anode is off.
- Without the macro: no BRIGHT port; full duty after GUARD.

Test Plan:
- Common settings: DIGITS=4, SCAN_DIV=4, GUARD=1, AN_ACTIVE_LOW=1.
- Reset held -> SEG=FF, AN=4'b1111, FRAME=0; after release with no LOAD, SEG stays FF for the full frame.
- LOAD DATA=16'h12AF, DP=4'b0100, DIGIT_EN=4'hF -> from the next frame: digit0 SEG=8'h8E (F), digit1 8'h88 (A), digit2 8'h24 (2, dp on), digit3 8'hF9 (1); AN cycles 1110, 1101, 1011, 0111, each preceded by one 1111 guard cycle.
- LOAD mid-frame with DATA=16'h0000 -> remaining digits of the current frame keep old glyphs; the next frame shows 8'hC0 on all digits.
- LOAD coincident with the wrap cycle, DATA=16'h8888 -> the frame starting at that wrap shows 8'h80 on all digits.
- DIGIT_EN=4'b0101 -> digits 1 and 3 show SEG=FF while AN still strobes their slots; FRAME pulses once every 16 cycles.
- Assert RST mid-slot on digit 2 -> AN=1111 and SEG=FF immediately; the first slot after release is digit 0.
